// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Captures one execute result per cycle and runs a req/gnt/rvalid data-memory
// transaction for loads and stores. It stalls execute via o_mem_ready and returns
// a registered result bundle to write-back.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned H/W accesses
// (adds the o_misaligned port).
module mem_stage #(
    parameter int unsigned ALEN = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ex_valid,
    input  logic            i_ex_mem_rd,
    input  logic            i_ex_mem_wr,
    input  logic [2:0]      i_ex_funct3,
    input  logic [ALEN-1:0] i_ex_addr,
    input  logic [XLEN-1:0] i_ex_store_data,
    input  logic            i_ex_rf_wr,
    input  logic [4:0]      i_ex_rf_wr_addr,
    input  logic [XLEN-1:0] i_ex_rf_wr_data,
    input  logic            i_ex_mem_to_reg,
    input  logic            i_ex_staller,
    output logic            o_mem_ready,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [ALEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic            o_misaligned,
`endif
    output logic            o_mem_valid,
    output logic            o_rf_wr,
    output logic [4:0]      o_rf_wr_addr,
    output logic [XLEN-1:0] o_rf_wr_data,
    output logic            o_mem_to_reg,
    output logic [XLEN-1:0] o_mem_data,
    output logic            o_staller
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_t;

    state_t state_q, state_d;

    // Holding registers for the instruction in flight
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic            rf_wr_h;
    logic [4:0]      rf_wr_addr_h;
    logic [XLEN-1:0] rf_wr_data_h;
    logic            mem_to_reg_h;
    logic            staller_h;

    logic            accept, is_mem, mis;
    logic            store_done, load_done;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new;
    logic [XLEN-1:0] sh_b, sh_h, ld_data;
    logic            misaligned_q;

    assign accept      = (state_q == StIdle) && i_ex_valid;
    assign is_mem      = i_ex_mem_rd | i_ex_mem_wr;
    assign store_done  = (state_q == StReq) && i_dmem_gnt && o_dmem_we;
    assign load_done   = (state_q == StRsp) && i_dmem_rvalid;
    assign o_mem_ready = (state_q == StIdle);
    assign o_dmem_req  = (state_q == StReq);

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis = is_mem && (((i_ex_funct3[1:0] == 2'b01) && i_ex_addr[0]) ||
                            ((i_ex_funct3[1:0] == 2'b10) && (i_ex_addr[1:0] != 2'b00)));
    assign o_misaligned = misaligned_q;
`else
    assign mis = 1'b0;
`endif

    // Byte-lane enables and lane-replicated store data for the incoming access
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_ex_store_data;
        case (i_ex_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << i_ex_addr[1:0];
                wdata_new = {4{i_ex_store_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {i_ex_addr[1], 1'b0};
                wdata_new = {2{i_ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign sh_b = i_dmem_rdata >> {addr_lo_q, 3'b000};
    assign sh_h = i_dmem_rdata >> {addr_lo_q[1], 4'b0000};

    // Load data alignment and sign/zero extension
    always_comb begin
        ld_data = i_dmem_rdata;
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){sh_b[7]}}, sh_b[7:0]};
            3'b001:  ld_data = {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, sh_b[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, sh_h[15:0]};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && is_mem && !mis) state_d = StReq;
            StReq:  if (i_dmem_gnt) state_d = o_dmem_we ? StIdle : StRsp;
            StRsp:  if (i_dmem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Capture the accepted instruction and the memory request it drives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            rf_wr_h      <= 1'b0;
            rf_wr_addr_h <= '0;
            rf_wr_data_h <= '0;
            mem_to_reg_h <= 1'b0;
            staller_h    <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
        end else if (accept) begin
            funct3_q     <= i_ex_funct3;
            addr_lo_q    <= i_ex_addr[1:0];
            rf_wr_h      <= i_ex_rf_wr;
            rf_wr_addr_h <= i_ex_rf_wr_addr;
            rf_wr_data_h <= i_ex_rf_wr_data;
            mem_to_reg_h <= i_ex_mem_to_reg;
            staller_h    <= i_ex_staller;
            // Bus stays quiet for ALU ops and trapped accesses
            if (is_mem && !mis) begin
                o_dmem_we    <= i_ex_mem_wr;
                o_dmem_addr  <= {i_ex_addr[ALEN-1:2], 2'b00};
                o_dmem_wdata <= wdata_new;
                o_dmem_be    <= be_new;
            end
        end
    end

    // Result bundle: valid, rf_wr and misaligned are single-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_mem_valid  <= 1'b0;
            o_rf_wr      <= 1'b0;
            o_rf_wr_addr <= '0;
            o_rf_wr_data <= '0;
            o_mem_to_reg <= 1'b0;
            o_mem_data   <= '0;
            o_staller    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            o_mem_valid  <= 1'b0;
            o_rf_wr      <= 1'b0;
            misaligned_q <= 1'b0;
            if (accept && (!is_mem || mis)) begin
                o_mem_valid  <= 1'b1;
                o_rf_wr      <= i_ex_rf_wr & ~mis;
                o_rf_wr_addr <= i_ex_rf_wr_addr;
                o_rf_wr_data <= i_ex_rf_wr_data;
                o_mem_to_reg <= i_ex_mem_to_reg;
                o_mem_data   <= '0;
                o_staller    <= i_ex_staller;
                misaligned_q <= mis;
            end else if (store_done || load_done) begin
                o_mem_valid  <= 1'b1;
                o_rf_wr      <= rf_wr_h;
                o_rf_wr_addr <= rf_wr_addr_h;
                o_rf_wr_data <= rf_wr_data_h;
                o_mem_to_reg <= mem_to_reg_h;
                o_mem_data   <= load_done ? ld_data : '0;
                o_staller    <= staller_h;
            end
        end
    end

`ifndef MEM_MISALIGN_CHECK_EN
    logic unused_mis;
    assign unused_mis = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected bundles are queued when
// an instruction is driven and compared when o_mem_valid fires.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_ex_valid, i_ex_mem_rd, i_ex_mem_wr;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_addr, i_ex_store_data, i_ex_rf_wr_data;
    logic        i_ex_rf_wr, i_ex_mem_to_reg, i_ex_staller;
    logic [4:0]  i_ex_rf_wr_addr;
    logic        o_mem_ready, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_mem_valid, o_rf_wr, o_mem_to_reg, o_staller;
    logic [4:0]  o_rf_wr_addr;
    logic [31:0] o_rf_wr_data, o_mem_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        o_misaligned;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rf_wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        m2r;
        logic [31:0] mdata;
        logic        mdata_chk;
        logic        staller;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_ex_valid      (i_ex_valid),
        .i_ex_mem_rd     (i_ex_mem_rd),
        .i_ex_mem_wr     (i_ex_mem_wr),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_addr       (i_ex_addr),
        .i_ex_store_data (i_ex_store_data),
        .i_ex_rf_wr      (i_ex_rf_wr),
        .i_ex_rf_wr_addr (i_ex_rf_wr_addr),
        .i_ex_rf_wr_data (i_ex_rf_wr_data),
        .i_ex_mem_to_reg (i_ex_mem_to_reg),
        .i_ex_staller    (i_ex_staller),
        .o_mem_ready     (o_mem_ready),
        .o_dmem_req      (o_dmem_req),
        .o_dmem_we       (o_dmem_we),
        .o_dmem_addr     (o_dmem_addr),
        .o_dmem_wdata    (o_dmem_wdata),
        .o_dmem_be       (o_dmem_be),
        .i_dmem_gnt      (i_dmem_gnt),
        .i_dmem_rvalid   (i_dmem_rvalid),
        .i_dmem_rdata    (i_dmem_rdata),
`ifdef MEM_MISALIGN_CHECK_EN
        .o_misaligned    (o_misaligned),
`endif
        .o_mem_valid     (o_mem_valid),
        .o_rf_wr         (o_rf_wr),
        .o_rf_wr_addr    (o_rf_wr_addr),
        .o_rf_wr_data    (o_rf_wr_data),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_mem_data      (o_mem_data),
        .o_staller       (o_staller)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load extraction
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (!o_mem_valid) begin
                check("rf_wr_idle", o_rf_wr, 0);
            end else if (sb.size() == 0) begin
                check("spurious_valid", o_mem_valid, 0);
            end else begin
                e = sb.pop_front();
                check("rf_wr", o_rf_wr, e.rf_wr);
                check("rf_wr_addr", o_rf_wr_addr, e.waddr);
                check("rf_wr_data", o_rf_wr_data, e.wdata);
                check("mem_to_reg", o_mem_to_reg, e.m2r);
                check("staller", o_staller, e.staller);
                if (e.mdata_chk) check("mem_data", o_mem_data, e.mdata);
`ifdef MEM_MISALIGN_CHECK_EN
                check("misaligned", o_misaligned, e.mis);
`endif
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_ready", o_mem_ready, 1);
        check("rst_req", o_dmem_req, 0);
        check("rst_we", o_dmem_we, 0);
        check("rst_daddr", o_dmem_addr, 0);
        check("rst_wdata", o_dmem_wdata, 0);
        check("rst_be", o_dmem_be, 0);
        check("rst_valid", o_mem_valid, 0);
        check("rst_rf_wr", o_rf_wr, 0);
        check("rst_rf_addr", o_rf_wr_addr, 0);
        check("rst_rf_data", o_rf_wr_data, 0);
        check("rst_m2r", o_mem_to_reg, 0);
        check("rst_mdata", o_mem_data, 0);
        check("rst_staller", o_staller, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        check("rst_mis", o_misaligned, 0);
`endif
    endtask

    // Drive one instruction at a falling edge and play the memory side of it.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic rfw, input logic [4:0] waddr, input logic [31:0] alu,
                         input logic m2r, input logic stl, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata, input logic mis_exp);
        exp_t        e;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        check("ready_idle", o_mem_ready, 1);
        i_ex_valid = 1'b1;  i_ex_mem_rd = rd;  i_ex_mem_wr = wr;  i_ex_funct3 = f3;
        i_ex_addr = addr;   i_ex_store_data = sdata;  i_ex_rf_wr = rfw;
        i_ex_rf_wr_addr = waddr;  i_ex_rf_wr_data = alu;  i_ex_mem_to_reg = m2r;
        i_ex_staller = stl;
        e.rf_wr = rfw & ~mis_exp;  e.waddr = waddr;  e.wdata = alu;  e.m2r = m2r;
        e.staller = stl;  e.mis = mis_exp;
        e.mdata = rd ? ld_model(f3, addr[1:0], rdata) : 32'h0;
        e.mdata_chk = !wr || mis_exp;
        sb.push_back(e);
        case (f3[1:0])
            2'b00:   begin ebe = 4'b0001 << addr[1:0];  ewd = {4{sdata[7:0]}};  end
            2'b01:   begin ebe = addr[1] ? 4'b1100 : 4'b0011;  ewd = {2{sdata[15:0]}}; end
            default: begin ebe = 4'b1111;  ewd = sdata;  end
        endcase
        @(negedge clk);
        i_ex_valid = 1'b0;
        if (!(rd | wr) || mis_exp) begin
            check("valid_lat", o_mem_valid, 1);
            check("no_req", o_dmem_req, 0);
            return;
        end
        check("req_up", o_dmem_req, 1);
        check("ready_low", o_mem_ready, 0);
        check("dmem_addr", o_dmem_addr, {addr[31:2], 2'b00});
        check("dmem_we", o_dmem_we, wr);
        if (wr) begin
            check("dmem_be", o_dmem_be, ebe);
            check("dmem_wdata", o_dmem_wdata, ewd);
        end
        for (int k = 0; k < gnt_wait; k++) begin
            @(negedge clk);
            check("req_held", o_dmem_req, 1);
            check("addr_held", o_dmem_addr, {addr[31:2], 2'b00});
            check("ready_wait", o_mem_ready, 0);
        end
        i_dmem_gnt = 1'b1;
        @(negedge clk);
        i_dmem_gnt = 1'b0;
        if (wr) begin
            check("valid_lat", o_mem_valid, 1);
            check("req_drop", o_dmem_req, 0);
            return;
        end
        check("req_rsp", o_dmem_req, 0);
        check("ready_rsp", o_mem_ready, 0);
        check("valid_early", o_mem_valid, 0);
        for (int k = 1; k < rv_wait; k++) @(negedge clk);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rdata;
        @(negedge clk);
        i_dmem_rvalid = 1'b0;
        check("valid_lat", o_mem_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3s [5];
        logic [31:0] a, w;
        logic [2:0]  f;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0;
        i_ex_valid = 0;  i_ex_mem_rd = 0;  i_ex_mem_wr = 0;  i_ex_funct3 = 0;
        i_ex_addr = 0;   i_ex_store_data = 0;  i_ex_rf_wr = 0;  i_ex_rf_wr_addr = 0;
        i_ex_rf_wr_data = 0;  i_ex_mem_to_reg = 0;  i_ex_staller = 0;
        i_dmem_gnt = 0;  i_dmem_rvalid = 0;  i_dmem_rdata = 0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op
        issue(0, 0, 3'b000, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 32'h0, 0);
        // SB to lane 3
        issue(0, 1, 3'b000, 32'h103, 32'hAB, 0, 5'd0, 32'h103, 0, 0, 0, 0, 32'h0, 0);
        // SH upper half, SW
        issue(0, 1, 3'b001, 32'h202, 32'hBEEF, 0, 5'd0, 32'h0, 0, 1, 1, 0, 32'h0, 0);
        issue(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 5'd0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        // LB / LBU of 0x80 in lane 2
        issue(1, 0, 3'b000, 32'h102, 32'h0, 1, 5'd7, 32'h102, 1, 0, 0, 1, 32'h00800000, 0);
        issue(1, 0, 3'b100, 32'h102, 32'h0, 1, 5'd8, 32'h102, 1, 0, 0, 1, 32'h00800000, 0);
        // LW with 3-cycle grant delay and rvalid 2 cycles after gnt
        issue(1, 0, 3'b010, 32'h400, 32'h0, 1, 5'd9, 32'h400, 1, 1, 3, 2, 32'h89ABCDEF, 0);

        // Back-to-back ALU ops, one per cycle
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            check("ready_b2b", o_mem_ready, 1);
            i_ex_valid = 1;  i_ex_mem_rd = 0;  i_ex_mem_wr = 0;  i_ex_rf_wr = 1;
            i_ex_rf_wr_addr = 5'(10 + i);  i_ex_rf_wr_data = 32'hA000 + i;
            i_ex_mem_to_reg = 0;  i_ex_staller = i[0];
            e.rf_wr = 1;  e.waddr = 5'(10 + i);  e.wdata = 32'hA000 + i;  e.m2r = 0;
            e.mdata = 0;  e.mdata_chk = 1;  e.staller = i[0];  e.mis = 0;
            sb.push_back(e);
            @(negedge clk);
        end
        i_ex_valid = 0;
        @(negedge clk);

        // gnt / rvalid while idle must be ignored
        i_dmem_gnt = 1;  i_dmem_rvalid = 1;
        @(negedge clk);
        i_dmem_gnt = 0;  i_dmem_rvalid = 0;
        check("idle_gnt_req", o_dmem_req, 0);
        check("idle_gnt_valid", o_mem_valid, 0);

        // Random aligned loads
        for (int i = 0; i < 10; i++) begin
            f = f3s[$urandom_range(4)];
            a = $urandom & 32'hFFFF_FFFC;
            if (f[1:0] == 2'b00) a[1:0] = 2'($urandom_range(3));
            else if (f[1:0] == 2'b01) a[1] = 1'($urandom_range(1));
            w = $urandom;
            issue(1, 0, f, a, 32'h0, 1, 5'(i + 1), a, 1, 0, $urandom_range(2),
                  $urandom_range(1, 3), w, 0);
        end

`ifdef MEM_MISALIGN_CHECK_EN
        issue(1, 0, 3'b010, 32'h102, 32'h0, 1, 5'd3, 32'h102, 1, 0, 0, 0, 32'h0, 1);
        issue(0, 1, 3'b001, 32'h101, 32'h55, 0, 5'd0, 32'h101, 0, 0, 0, 0, 32'h0, 1);
`endif

        // Reset while a load waits for rvalid; the late rvalid must be dropped
        i_ex_valid = 1;  i_ex_mem_rd = 1;  i_ex_mem_wr = 0;  i_ex_funct3 = 3'b010;
        i_ex_addr = 32'h500;  i_ex_rf_wr = 1;  i_ex_rf_wr_addr = 5'd4;
        @(negedge clk);
        i_ex_valid = 0;  i_dmem_gnt = 1;
        @(negedge clk);
        i_dmem_gnt = 0;
        check("rsp_state_req", o_dmem_req, 0);
        check("rsp_state_ready", o_mem_ready, 0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check_reset_vals();
        i_dmem_rvalid = 1;  i_dmem_rdata = 32'h12345678;
        @(negedge clk);
        i_dmem_rvalid = 0;
        check("late_rvalid", o_mem_valid, 0);
        @(negedge clk);
        check("late_rvalid2", o_mem_valid, 0);
        check("ready_after_rst", o_mem_ready, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
